mymul_driver: RTL and testbench

- Avalon-MM master sequencer that sits directly upstream of the memory-mapped 32x32 multiplier slave.
- Accepts operand pairs on a valid/ready stream and drives the full slave register protocol: write A, write B, pulse CTL, wait, read LO, read HI.
- Returns the 64-bit product on a valid/ready output stream.
- Offloads the register choreography from the Nios software so an operand pair costs one stream transfer instead of six bus accesses.

---
 rtl/mymul_driver.sv | 155 +++++++++++++++
 tb/tb_mymul_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mymul_driver.sv
// Avalon-MM master that walks the 32x32 multiplier slave through its register
// protocol (A, B, CTL 0->1, settle, LO, HI) for each operand pair on a stream.
module mymul_driver #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [15:0] done_count
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_CLR, WR_GO, SETTLE, RD_LO, RD_HI, OUT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] done_q, done_d;

  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic [2:0]  word_d;

  logic accept, wr_ack, rd_ack, out_ack;
  assign accept  = in_valid && in_ready_q;
  assign wr_ack  = avm_write_q && !avm_waitrequest;
  assign rd_ack  = avm_read_q && !avm_waitrequest;
  assign out_ack = out_valid_q && out_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      a_q             <= '0;
      b_q             <= '0;
      res_q           <= '0;
      cnt_q           <= '0;
      done_q          <= '0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= BASE_ADDR;
      avm_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      a_q             <= a_d;
      b_q             <= b_d;
      res_q           <= res_d;
      cnt_q           <= cnt_d;
      done_q          <= done_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  // Next state; every bus phase advances only on an accepted transfer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: if (accept) begin
        a_d     = in_a;
        b_d     = in_b;
        state_d = WR_A;
      end
      WR_A:   if (wr_ack) state_d = WR_B;
      WR_B:   if (wr_ack) state_d = WR_CLR;
      WR_CLR: if (wr_ack) state_d = WR_GO;
      WR_GO: if (wr_ack) begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LD;
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RD_LO;
      end
      RD_LO: if (rd_ack) begin
        res_d[31:0] = avm_readdata;
        state_d     = RD_HI;
      end
      RD_HI: if (rd_ack) begin
        res_d[63:32] = avm_readdata;
        state_d      = OUT;
      end
      OUT: if (out_ack) begin
        done_d  = done_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and handshake outputs are registered from the upcoming state, so a
  // stalled transfer re-presents identical address/data/strobe every cycle.
  always_comb begin
    in_ready_d      = (state_d == IDLE);
    out_valid_d     = (state_d == OUT);
    avm_read_d      = 1'b0;
    avm_write_d     = 1'b0;
    avm_writedata_d = '0;
    word_d          = 3'd0;
    unique case (state_d)
      WR_A:   begin avm_write_d = 1'b1; word_d = 3'd0; avm_writedata_d = a_d;   end
      WR_B:   begin avm_write_d = 1'b1; word_d = 3'd1; avm_writedata_d = b_d;   end
      WR_CLR: begin avm_write_d = 1'b1; word_d = 3'd4; avm_writedata_d = 32'd0; end
      WR_GO:  begin avm_write_d = 1'b1; word_d = 3'd4; avm_writedata_d = 32'd1; end
      RD_LO:  begin avm_read_d  = 1'b1; word_d = 3'd2; end
      RD_HI:  begin avm_read_d  = 1'b1; word_d = 3'd3; end
      default: ;
    endcase
    avm_address_d = BASE_ADDR + {27'd0, word_d, 2'b00};
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result    = res_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign busy          = (state_q != IDLE);
  assign done_count    = done_q;

endmodule

// File: tb/tb_mymul_driver.sv
// Bench for mymul_driver: behavioural multiplier slave, scoreboard of expected
// products and bus sequences, table-driven vectors plus stall/backpressure/reset cases.
module tb_mymul_driver;
  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [63:0] out_result;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest = 1'b0, busy;
  logic [15:0] done_count;

  mymul_driver #(.BASE_ADDR(BASE), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [63:0] res; int lat; logic sync; } vec_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [63:0] res; int lat; } sb_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;

  sb_t  sb[$];
  bus_t bus_q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0;
  logic [63:0] cur_exp = '0;
  int   cur_lat = 0;
  int   stall_b = 0, stall_hi = 0, cnt_b = 0, cnt_hi = 0;
  logic ov_prev = 1'b0, hold_chk = 1'b0;
  logic [31:0] h_addr = '0, h_data = '0;
  logic [1:0]  h_strb = '0;
  sb_t  e;
  bus_t t;
  logic [31:0] exp_off [6] = '{32'd0, 32'd4, 32'd16, 32'd16, 32'd8, 32'd12};
  logic        exp_we  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: word map 0=A 1=B 2=LO 3=HI 4=CTL; result latched 2 edges after CTL 0->1
  logic [31:0] s_a = '0, s_b = '0;
  logic [63:0] s_res = '0;
  logic        s_ctl = 1'b0;
  int          s_pend = 0;
  wire  [31:0] s_off = avm_address - BASE;
  assign avm_readdata = (s_off[4:2] == 3'd2) ? s_res[31:0] :
                        (s_off[4:2] == 3'd3) ? s_res[63:32] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_pend == 1) s_res <= {32'd0, s_a} * {32'd0, s_b};
    if (s_pend != 0) s_pend <= s_pend - 1;
    if (avm_write && !avm_waitrequest) begin
      case (s_off[4:2])
        3'd0: s_a <= avm_writedata;
        3'd1: s_b <= avm_writedata;
        3'd4: begin
          if (avm_writedata[0] && !s_ctl) s_pend <= 2;
          s_ctl <= avm_writedata[0];
        end
        default: ;
      endcase
    end
  end

  // Monitor: stall injection, hold checks, bus log, scoreboard push/pop
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      bus_q.delete();
      ov_prev = 1'b0; hold_chk = 1'b0; cnt_b = 0; cnt_hi = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_addr", 64'(avm_address), 64'(h_addr));
        chk("hold_data", 64'(avm_writedata), 64'(h_data));
        chk("hold_strb", 64'({avm_read, avm_write}), 64'(h_strb));
      end
      chk("rw_excl", 64'(avm_read & avm_write), 64'd0);
      avm_waitrequest = 1'b0;
      if (avm_write && avm_address == BASE + 32'd4) begin
        if (cnt_b < stall_b) begin avm_waitrequest = 1'b1; cnt_b++; end
      end else cnt_b = 0;
      if (avm_read && avm_address == BASE + 32'd12) begin
        if (cnt_hi < stall_hi) begin avm_waitrequest = 1'b1; cnt_hi++; end
      end else cnt_hi = 0;
      hold_chk = (avm_read | avm_write) & avm_waitrequest;
      h_addr = avm_address; h_data = avm_writedata; h_strb = {avm_read, avm_write};
      if ((avm_read | avm_write) && !avm_waitrequest)
        bus_q.push_back('{avm_write, avm_address, avm_writedata});
      if (in_valid && in_ready) begin
        sb.push_back('{in_a, in_b, cur_exp, cur_lat});
        acc_cyc = cyc;
      end
      if (out_valid && !ov_prev && sb.size() > 0 && sb[0].lat != 0)
        chk("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %0h want none", out_result);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("bus_count", 64'(bus_q.size()), 64'd6);
          if (bus_q.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
              t = bus_q.pop_front();
              chk("bus_we", 64'(t.we), 64'(exp_we[k]));
              chk("bus_addr", 64'(t.addr), 64'(BASE + exp_off[k]));
              wd = (k == 0) ? e.a : (k == 1) ? e.b : (k == 2) ? 32'd0 : 32'd1;
              if (exp_we[k]) chk("bus_data", 64'(t.data), 64'(wd));
            end
          end else bus_q.delete();
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] r, input int lat);
    int n = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; cur_exp = r; cur_lat = lat; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] n);
    int k = 0;
    while (done_count != n && k < 400) begin @(posedge clk); #1; k++; end
    chk("done_count", 64'(done_count), 64'(n));
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_write", 64'(avm_write), 64'd0);
    chk("rst_avm_address", 64'(avm_address), 64'(BASE));
    chk("rst_avm_writedata", 64'(avm_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_count", 64'(done_count), 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int k;
    tbl[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, 9, 1'b1};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 9, 1'b1};
    tbl[2] = '{32'd7,          32'd9,          64'd63,                  9, 1'b0};
    tbl[3] = '{32'd0,          32'h123,        64'd0,                   9, 1'b0};
    tbl[4] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 9, 1'b0};
    tbl[5] = '{32'hDEAD_BEEF,  32'd2,          64'h0000_0001_BD5B_7DDE, 9, 1'b1};

    repeat (2) @(posedge clk);
    #1 chk_reset();
    reset_n = 1'b1;

    // Table vectors; entries without sync are streamed back to back
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);
      if (tbl[i].sync) wait_done(16'(i + 1));
    end

    // Waitrequest: 3 stalls on the B write, 2 on the HI read -> latency 9+5
    stall_b = 3; stall_hi = 2;
    send(32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, 14);
    wait_done(16'd7);
    stall_b = 0; stall_hi = 0;

    // Output backpressure held for 10 cycles
    out_ready = 1'b0;
    send(32'd100000, 32'd100000, 64'h0000_0002_540B_E400, 9);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_result", out_result, 64'h0000_0002_540B_E400);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_bus_idle", 64'({avm_read, avm_write}), 64'd0);
    end
    chk("bp_done_hold", 64'(done_count), 64'd7);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(16'd8);

    // Reset during SETTLE, then a clean operation
    send(32'd11, 32'd13, 64'd143, 9);
    k = 0;
    while (bus_q.size() < 4 && k < 100) begin @(posedge clk); k++; end
    @(negedge clk); #2 reset_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(32'd6, 32'd7, 64'd42, 9);
    wait_done(16'd1);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
